serial_nibble_loader: RTL
=========================

SERIAL_NIBBLE_LOADER -- requirements
Module: serial_nibble_loader

Interface
REQ-001 SHALL have parameter PARITY_EN, default 1, meaning: 1 = frame carries an even-parity bit after the data; 0 = no parity bit.
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port i_start, input, 1 bit: frame start strobe, sampled on the clock edge.
REQ-005 SHALL have port i_valid, input, 1 bit: qualifies i_bit on this clock edge.
REQ-006 SHALL have port i_bit, input, 1 bit: serial data, LSB first, then the parity bit.
REQ-007 SHALL have port o_d, output, 4 bits: assembled nibble; drives the downstream 4-bit enabled register data input.
REQ-008 SHALL have port o_en, output, 1 bit: one-cycle load pulse; drives the downstream register enable.
REQ-009 SHALL have port o_busy, output, 1 bit: high while a frame is in progress (states SHIFT or PARITY).
REQ-010 SHALL have port o_err, output, 1 bit: sticky parity-error flag.

Function
REQ-011 SHALL use an FSM with states IDLE, SHIFT, PARITY, LOAD; all outputs are registered or decoded from state only.
REQ-012 IDLE: on i_start=1, SHALL go to SHIFT, clear the bit counter to 0, clear the shift register, and clear o_err.
REQ-013 SHIFT: on each edge with i_valid=1, SHALL shift i_bit into position count (bit 0 first) and increment the 2-bit counter.
REQ-014 SHIFT: when the 4th bit is accepted (counter = 3), SHALL go to PARITY if PARITY_EN=1, else to LOAD.
REQ-015 PARITY: on i_valid=1, SHALL go to LOAD if XOR(nibble, i_bit)=0; otherwise SHALL set o_err=1 and go to IDLE with no o_en pulse.
REQ-016 LOAD: o_en SHALL be 1 for exactly one cycle; the state then SHALL return to IDLE unconditionally.
REQ-017 Latency: o_en SHALL be high in the cycle immediately after the edge that accepted the final bit (parity bit or data bit 3), so the downstream register captures o_d on the following edge.
REQ-018 o_d SHALL be stable from the entry to LOAD until the next i_start is accepted; o_d SHALL NOT change while o_en=1.
REQ-019 Edges with i_valid=0 SHALL leave state, counter and o_d unchanged (stalls of any length).
REQ-020 i_start=1 in SHIFT or PARITY SHALL abort the current frame and restart per REQ-012; i_valid on that same edge SHALL be ignored.
REQ-021 i_start=1 in LOAD SHALL be ignored; the o_en pulse still completes.
REQ-022 i_valid without a preceding i_start (in IDLE) SHALL be ignored.
REQ-023 o_err SHALL remain set until the next accepted i_start or reset.

Reset
REQ-024 While i_rst=1, regardless of clock: state=IDLE, counter=0, o_d=4'h0, o_en=0, o_busy=0, o_err=0.
REQ-025 Reset asserted mid-frame SHALL drop the frame; no o_en pulse SHALL follow deassertion.
REQ-026 After deassertion, the first i_start SHALL be honoured on the first rising edge.

Structure
REQ-027 Package loader_pkg SHALL hold the state enum type (IDLE, SHIFT, PARITY, LOAD) and the constant NIBBLE_W=4.
REQ-028 The serial-to-parallel datapath SHALL be one sub-module, shift_in_4 (i_clk, i_rst, i_clr, i_en, i_bit, o_q[3:0]); the FSM, counter and parity logic stay in the top.

Verification
REQ-029 Reset, then i_start, then bits 1,0,1,1 and parity 1 on consecutive valid cycles -> o_d=4'hD, a single o_en pulse one cycle after the parity edge, o_err=0.
REQ-030 Same frame with parity bit 0 -> no o_en, o_err=1, o_busy=0; next i_start -> o_err=0.
REQ-031 Frame 0,1,1,0 with parity 0 and i_valid=0 gaps of 3 cycles between bits -> o_d=4'h6, one o_en pulse, o_d held unchanged for the gap cycles.
REQ-032 Two data bits, then i_start with i_valid=1, then frame 1,1,1,1 with parity 0 -> o_d=4'hF; the aborted bits have no effect.
REQ-033 i_rst asserted asynchronously (between edges) after 3 data bits -> all outputs 0 at once; no o_en after release.
REQ-034 PARITY_EN=0, frame 0,0,0,1 -> o_d=4'h8, o_en one cycle after the 4th data bit edge.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the serial nibble loader.
// Holds the FSM state encoding, the nibble width and the parity helper.
package loader_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        LOAD   = 2'd3
    } state_t;

    // True when the nibble and its parity bit carry an even number of ones.
    function automatic logic even_parity_ok(input logic [NIBBLE_W-1:0] nib,
                                            input logic                p);
        return ~(^{nib, p});
    endfunction

endpackage

// File: rtl/shift_in_4.sv
// Serial-to-parallel register: the first bit shifted in ends up in bit 0
// after four enabled edges. The clear input has priority over the enable.
module shift_in_4
    import loader_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_clr,
    input  logic                i_en,
    input  logic                i_bit,
    output logic [NIBBLE_W-1:0] o_q
);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_q <= '0;
        end else if (i_clr) begin
            o_q <= '0;
        end else if (i_en) begin
            o_q <= {i_bit, o_q[NIBBLE_W-1:1]};
        end
    end

endmodule

// File: rtl/serial_nibble_loader.sv
// Collects a 4-bit LSB-first serial frame with optional even parity and
// emits a one-cycle load strobe for a downstream enabled register.
module serial_nibble_loader
    import loader_pkg::*;
#(
    parameter int PARITY_EN = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic                i_valid,
    input  logic                i_bit,
    output logic [NIBBLE_W-1:0] o_d,
    output logic                o_en,
    output logic                o_busy,
    output logic                o_err
);

    state_t     state;
    state_t     state_nx;
    logic [1:0] cnt;
    logic [1:0] cnt_nx;
    logic       err_nx;
    logic       clr;
    logic       shift_en;

    shift_in_4 u_shift (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (clr),
        .i_en  (shift_en),
        .i_bit (i_bit),
        .o_q   (o_d)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            cnt   <= 2'd0;
            o_err <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            o_err <= err_nx;
        end
    end

    // A start seen in IDLE, SHIFT or PARITY (re)opens a frame; any
    // i_valid on that same edge is deliberately dropped.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        err_nx   = o_err;
        clr      = 1'b0;
        shift_en = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_nx = SHIFT;
                    cnt_nx   = 2'd0;
                    clr      = 1'b1;
                    err_nx   = 1'b0;
                end
            end
            SHIFT: begin
                if (i_start) begin
                    state_nx = SHIFT;
                    cnt_nx   = 2'd0;
                    clr      = 1'b1;
                    err_nx   = 1'b0;
                end else if (i_valid) begin
                    shift_en = 1'b1;
                    cnt_nx   = cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state_nx = (PARITY_EN != 0) ? PARITY : LOAD;
                    end
                end
            end
            PARITY: begin
                if (i_start) begin
                    state_nx = SHIFT;
                    cnt_nx   = 2'd0;
                    clr      = 1'b1;
                    err_nx   = 1'b0;
                end else if (i_valid) begin
                    if (even_parity_ok(o_d, i_bit)) begin
                        state_nx = LOAD;
                    end else begin
                        state_nx = IDLE;
                        err_nx   = 1'b1;
                    end
                end
            end
            LOAD: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign o_en   = (state == LOAD);
    assign o_busy = (state == SHIFT) || (state == PARITY);

endmodule
